// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and legal WIDTH bounds.
package serial_add_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

   function automatic bit width_ok(input int w);
      return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
   endfunction

endpackage

// File: rtl/full_add_bit.sv
// Combinational 1-bit full adder assembled from two half adders and an OR.
module full_add_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic hs1, hc1, hc2;

   assign hs1  = a ^ b;
   assign hc1  = a & b;
   assign sum  = hs1 ^ cin;
   assign hc2  = hs1 & cin;
   assign cout = hc1 | hc2;

endmodule

// File: rtl/serial_add_param.sv
// Bit-serial WIDTH-bit adder: one bit per clock through a single full-adder cell.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN (adds port sub).
module serial_add_param
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   generate
      if (!width_ok(WIDTH)) begin : g_bad_width
         $error("serial_add_param: WIDTH out of range 2..32");
      end
   endgenerate

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_r, b_r;
   logic             c_r;
   logic             load, step, finish;
   logic             sub_en;
   logic             fa_s, fa_c;

`ifdef SERIAL_ADD_SUB_EN
   assign sub_en = sub;
`else
   assign sub_en = 1'b0;
`endif

   full_add_bit u_fa (
      .a    (a_r[0]),
      .b    (b_r[0]),
      .cin  (c_r),
      .sum  (fa_s),
      .cout (fa_c)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      load    = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_n = ST_RUN;
               load    = 1'b1;
            end
         end
         ST_RUN: begin
            step = 1'b1;
            if (cnt == LAST) begin
               state_n = ST_IDLE;
               finish  = 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign busy = (state == ST_RUN);

   // Operand shift registers need no reset: they are always loaded before use.
   always_ff @(posedge clk) begin
      if (load) begin
         a_r <= a;
         b_r <= b ^ {WIDTH{sub_en}};
      end else if (step) begin
         a_r <= a_r >> 1;
         b_r <= b_r >> 1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done  <= 1'b0;
         sum   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         c_r   <= 1'b0;
      end else begin
         done <= finish;
         if (load) begin
            c_r <= sub_en;
            cnt <= '0;
         end else if (step) begin
            // Sum fills from the MSB side so bit 0 lands at position 0 after WIDTH shifts.
            sum <= {fa_s, sum[WIDTH-1:1]};
            c_r <= fa_c;
            cnt <= finish ? '0 : cnt + 1'b1;
            if (finish) carry <= fa_c;
         end
      end
   end

endmodule

// File: tb/tb_serial_add_param.sv
// Directed bench for serial_add_param (WIDTH=8); subtract vectors run when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_param;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a, b;
   logic       busy, done, carry;
   logic [7:0] sum;
`ifdef SERIAL_ADD_SUB_EN
   logic       sub;
`endif

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   serial_add_param #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
`ifdef SERIAL_ADD_SUB_EN
      .sub   (sub),
`endif
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .carry (carry)
   );

   typedef struct {
      logic [7:0] va;
      logic [7:0] vb;
      logic [7:0] exp_sum;
      logic       exp_carry;
   } vec_t;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
   endtask

   // Waits up to 20 edges for done; returns edges counted since the caller's reference edge.
   task automatic wait_done(input int already, output int n, output logic seen);
      n = already;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(posedge clk);
         #1;
         n++;
         if (done) seen = 1'b1;
      end
   endtask

   task automatic count_done(input int cycles, output int pulses);
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
   endtask

   task automatic do_op(input string nm, input logic [7:0] ta, input logic [7:0] tb,
                        input logic [7:0] es, input logic ec);
      int   n;
      logic seen;
      @(negedge clk);
      a = ta;
      b = tb;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({nm, "_busy"}, busy, 1);
      wait_done(0, n, seen);
      check({nm, "_done_seen"}, seen, 1);
      check({nm, "_latency"}, n, 8);
      check({nm, "_sum"}, sum, es);
      check({nm, "_carry"}, carry, ec);
      check({nm, "_idle"}, busy, 0);
      @(posedge clk);
      #1;
      check({nm, "_done_one_cycle"}, done, 0);
   endtask

   vec_t vecs[6];

   initial begin
      int   n, pulses;
      logic seen;

      vecs[0] = '{8'h0F, 8'h01, 8'h10, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
      vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
      vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
      vecs[4] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
      vecs[5] = '{8'h80, 8'h7F, 8'hFF, 1'b0};

      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
`ifdef SERIAL_ADD_SUB_EN
      sub = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", sum, 0);
      check("rst_carry", carry, 0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++)
         do_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].exp_sum, vecs[i].exp_carry);

      // Start pulsed again mid-run must be ignored.
      @(negedge clk);
      a = 8'h12; b = 8'h34; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #1 begin a = 8'hAA; start = 1'b1; end
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(3, n, seen);
      check("ign_done_seen", seen, 1);
      check("ign_latency", n, 8);
      check("ign_sum", sum, 8'h46);
      check("ign_carry", carry, 0);
      count_done(12, pulses);
      check("ign_single_done", pulses, 0);

      // Reset mid-operation aborts without a done pulse.
      @(negedge clk);
      a = 8'h55; b = 8'h55; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_busy", busy, 0);
      check("abort_sum", sum, 0);
      check("abort_carry", carry, 0);
      check("abort_done", done, 0);
      rst = 1'b0;
      count_done(12, pulses);
      check("abort_no_done", pulses, 0);
      do_op("after_abort", 8'h01, 8'h01, 8'h02, 1'b0);

      // Back-to-back: start held through done.
      @(negedge clk);
      a = 8'h80; b = 8'h80; start = 1'b1;
      @(posedge clk);
      #1 begin a = 8'h03; b = 8'h04; end
      wait_done(0, n, seen);
      check("b2b1_done_seen", seen, 1);
      check("b2b1_latency", n, 8);
      check("b2b1_sum", sum, 8'h00);
      check("b2b1_carry", carry, 1);
      @(posedge clk);
      #1 start = 1'b0;
      check("b2b2_busy", busy, 1);
      wait_done(0, n, seen);
      check("b2b2_done_seen", seen, 1);
      check("b2b2_latency", n, 8);
      check("b2b2_sum", sum, 8'h07);
      check("b2b2_carry", carry, 0);

`ifdef SERIAL_ADD_SUB_EN
      sub = 1'b1;
      do_op("sub_borrow", 8'h05, 8'h07, 8'hFE, 1'b0);
      do_op("sub_noborrow", 8'h07, 8'h05, 8'h02, 1'b1);
      sub = 1'b0;
      do_op("add_after_sub", 8'h07, 8'h05, 8'h0C, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
